calc_entry_fsm: RTL and testbench

Operand/operator entry controller directly downstream of the keypad input stage. It consumes one 4-bit key code per valid pulse and builds decimal operands as binary values. It captures the operator, launches the arithmetic unit via a start/done handshake, and holds the value the display stage shows.

---
 rtl/calc_pkg.sv | 58 +++++
 rtl/digit_accum.sv | 39 +++
 rtl/calc_entry_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator entry controller:
//   - keypad key codes (digits 0-9 plus operator/clear/equals codes)
//   - arithmetic operator encodings driven on op_code
//   - controller state type
//   - default operand digit limit
// Configuration macro used by the top level: KEY_SYNC_EN (see calc_entry_fsm).
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int MAX_DIGITS_DEF = 3;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_OP_WAIT  = 3'd1,
    ST_ENTER_B  = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_SHOW     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  // True for the decimal digit keys 0..9.
  function automatic logic key_is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // True for the four arithmetic operator keys.
  function automatic logic key_is_op(input logic [3:0] code);
    return ((code >= KEY_ADD) && (code <= KEY_DIV));
  endfunction

  // Operator key code to op_code encoding.
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    logic [1:0] op;
    case (code)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/digit_accum.sv
// -----------------------------------------------------------------------------
// digit_accum
// Combinational decimal accumulator: next = cur*10 + digit, evaluated with four
// extra bits so an overflow past WIDTH bits is visible. The digit is accepted
// only when the result still fits in WIDTH bits and the operand has fewer than
// MAX_DIGITS digits so far.
// Ports:
//   cur_i    current operand value
//   digit_i  incoming decimal digit (0..9)
//   count_i  digits already entered for this operand
//   next_o   accumulated value (meaningful only when accept_o=1)
//   accept_o digit may be taken
// -----------------------------------------------------------------------------
module digit_accum #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 2
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [3:0]       digit_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [WIDTH-1:0] next_o,
  output logic             accept_o
);

  logic [WIDTH+3:0] wide_s;

  // Widened multiply-add and acceptance decision.
  always_comb begin
    wide_s = ({4'b0000, cur_i} * (WIDTH+4)'(10)) + (WIDTH+4)'(digit_i);
    next_o = wide_s[WIDTH-1:0];
    if ((wide_s[WIDTH+3:WIDTH] == 4'b0000) && (count_i < CNT_W'(MAX_DIGITS))) begin
      accept_o = 1'b1;
    end else begin
      accept_o = 1'b0;
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// -----------------------------------------------------------------------------
// calc_entry_fsm
// Operand/operator entry controller between the keypad stage and the
// arithmetic unit. Builds decimal operands, latches the operator, launches the
// arithmetic unit with a one-cycle calc_start and holds the displayed value.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   key_value, key_valid  key code and its qualifier from the keypad stage
//   calc_done/result/err  completion handshake from the arithmetic unit
//   op_a, op_b, op_code   operands and operator to the arithmetic unit
//   calc_start            one-cycle launch pulse
//   disp_val              value for the display stage
//   error                 sticky error flag (cleared only by clear key/reset)
// Optional build macro KEY_SYNC_EN: key_valid is treated as an asynchronous
// level, synchronised by two flops, rising-edge detected, and key_value is
// registered on that edge (3 extra cycles of input latency). Without it,
// key_valid is a one-cycle clk-domain pulse used directly.
// -----------------------------------------------------------------------------
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_value,
  input  logic             key_valid,
  input  logic             calc_done,
  input  logic [WIDTH-1:0] calc_result,
  input  logic             calc_err,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_code,
  output logic             calc_start,
  output logic [WIDTH-1:0] disp_val,
  output logic             error
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic             key_vld_s;
  logic [3:0]       key_code_s;

`ifdef KEY_SYNC_EN
  logic       sync1_q;
  logic       sync2_q;
  logic       sync3_q;
  logic       key_vld_q;
  logic [3:0] key_code_q;

  // Two-flop synchroniser, edge detect and key capture on the detected edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      key_vld_q  <= 1'b0;
      key_code_q <= 4'd0;
    end else begin
      sync1_q   <= key_valid;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      key_vld_q <= sync2_q & ~sync3_q;
      if (sync2_q && !sync3_q) begin
        key_code_q <= key_value;
      end
    end
  end

  assign key_vld_s  = key_vld_q;
  assign key_code_s = key_code_q;
`else
  assign key_vld_s  = key_valid;
  assign key_code_s = key_value;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [1:0]       op_code_q;
  logic             calc_start_q;
  logic [WIDTH-1:0] disp_val_q;
  logic             error_q;
  logic [CNT_W-1:0] count_q;
  logic             pend_q;
  logic [1:0]       pend_code_q;

  logic             is_digit_s;
  logic             is_op_s;
  logic             is_clr_s;
  logic             is_eq_s;
  logic [WIDTH-1:0] acc_cur_s;
  logic [WIDTH-1:0] acc_d;
  logic             acc_ok_s;
  logic [WIDTH-1:0] digit_val_s;

  assign is_digit_s  = key_vld_s && key_is_digit(key_code_s);
  assign is_op_s     = key_vld_s && key_is_op(key_code_s);
  assign is_clr_s    = key_vld_s && (key_code_s == KEY_CLR);
  assign is_eq_s     = key_vld_s && (key_code_s == KEY_EQ);
  assign digit_val_s = WIDTH'(key_code_s);

  // Single accumulator shared between operands: B only while entering B.
  always_comb begin
    if (state_q == ST_ENTER_B) begin
      acc_cur_s = op_b_q;
    end else begin
      acc_cur_s = op_a_q;
    end
  end

  digit_accum #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digit_accum (
    .cur_i    (acc_cur_s),
    .digit_i  (key_code_s),
    .count_i  (count_q),
    .next_o   (acc_d),
    .accept_o (acc_ok_s)
  );

  // Entry controller: state, operands, display and launch pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ENTER_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= OP_ADD;
      calc_start_q <= 1'b0;
      disp_val_q   <= '0;
      error_q      <= 1'b0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_code_q  <= OP_ADD;
    end else begin
      calc_start_q <= 1'b0;
      // Clear beats everything, including a calc_done in the same cycle.
      if (is_clr_s) begin
        state_q     <= ST_ENTER_A;
        op_a_q      <= '0;
        op_b_q      <= '0;
        op_code_q   <= OP_ADD;
        disp_val_q  <= '0;
        error_q     <= 1'b0;
        count_q     <= '0;
        pend_q      <= 1'b0;
        pend_code_q <= OP_ADD;
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            if (is_digit_s && acc_ok_s) begin
              op_a_q     <= acc_d;
              disp_val_q <= acc_d;
              count_q    <= count_q + CNT_W'(1);
            end else if (is_op_s) begin
              op_code_q <= key_to_op(key_code_s);
              state_q   <= ST_OP_WAIT;
            end
          end
          ST_OP_WAIT: begin
            // First digit of B starts a fresh operand; display follows it.
            if (is_digit_s) begin
              op_b_q     <= digit_val_s;
              disp_val_q <= digit_val_s;
              count_q    <= CNT_W'(1);
              state_q    <= ST_ENTER_B;
            end else if (is_op_s) begin
              op_code_q <= key_to_op(key_code_s);
            end
          end
          ST_ENTER_B: begin
            if (is_digit_s && acc_ok_s) begin
              op_b_q     <= acc_d;
              disp_val_q <= acc_d;
              count_q    <= count_q + CNT_W'(1);
            end else if (is_op_s || is_eq_s) begin
              // op_code must stay stable for the running calculation, so a
              // chaining operator is parked until the result comes back.
              calc_start_q <= 1'b1;
              state_q      <= ST_WAIT_RES;
              pend_q       <= is_op_s;
              pend_code_q  <= key_to_op(key_code_s);
            end
          end
          ST_WAIT_RES: begin
            if (calc_done) begin
              if (calc_err) begin
                error_q    <= 1'b1;
                disp_val_q <= '0;
                pend_q     <= 1'b0;
                state_q    <= ST_ERROR;
              end else begin
                op_a_q     <= calc_result;
                disp_val_q <= calc_result;
                if (pend_q) begin
                  op_code_q <= pend_code_q;
                  pend_q    <= 1'b0;
                  state_q   <= ST_OP_WAIT;
                end else begin
                  state_q <= ST_SHOW;
                end
              end
            end
          end
          ST_SHOW: begin
            if (is_digit_s) begin
              op_a_q     <= digit_val_s;
              disp_val_q <= digit_val_s;
              count_q    <= CNT_W'(1);
              state_q    <= ST_ENTER_A;
            end else if (is_op_s) begin
              op_code_q <= key_to_op(key_code_s);
              op_b_q    <= '0;
              state_q   <= ST_OP_WAIT;
            end
          end
          ST_ERROR: begin
            state_q <= ST_ERROR;
          end
          default: begin
            state_q <= ST_ENTER_A;
          end
        endcase
      end
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_code    = op_code_q;
  assign calc_start = calc_start_q;
  assign disp_val   = disp_val_q;
  assign error      = error_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// -----------------------------------------------------------------------------
// tb_calc_entry_fsm
// Self-checking bench for calc_entry_fsm (default build, direct key pulses).
// Directed scenarios from the calculator use cases are followed by random key
// and completion traffic; a behavioural calculator model predicts every output.
// -----------------------------------------------------------------------------
module tb_calc_entry_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_value;
  logic       key_valid;
  logic       calc_done;
  logic [7:0] calc_result;
  logic       calc_err;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_code;
  logic       calc_start;
  logic [7:0] disp_val;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.WIDTH(8), .MAX_DIGITS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_value   (key_value),
    .key_valid   (key_valid),
    .calc_done   (calc_done),
    .calc_result (calc_result),
    .calc_err    (calc_err),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_code     (op_code),
    .calc_start  (calc_start),
    .disp_val    (disp_val),
    .error       (error)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural calculator model ----------------
  typedef enum int {M_FIRST, M_OPER, M_SECOND, M_BUSY, M_RESULT, M_FAULT} mode_t;
  mode_t m_mode;
  int m_a, m_b, m_code, m_disp, m_err, m_digits, m_start, m_chain, m_chain_code;

  function automatic void m_reset();
    m_mode = M_FIRST; m_a = 0; m_b = 0; m_code = 0; m_disp = 0;
    m_err = 0; m_digits = 0; m_start = 0; m_chain = 0; m_chain_code = 0;
  endfunction

  // Append a decimal digit to a value if it still fits and the limit allows.
  function automatic int append_digit(input int v, input int d);
    int n;
    n = v * 10 + d;
    if (n <= 255 && m_digits < 3) begin
      m_digits++;
      m_disp = n;
      return n;
    end
    return v;
  endfunction

  function automatic void model_step(input bit kv, input int kc, input bit dn, input int rs, input bit er);
    bit dig, oper, eq;
    dig = kv && kc <= 9;
    oper = kv && kc >= 10 && kc <= 13;
    eq = kv && kc == 15;
    m_start = 0;
    if (kv && kc == 14) begin
      m_reset();
      return;
    end
    case (m_mode)
      M_FIRST:  if (dig) m_a = append_digit(m_a, kc);
                else if (oper) begin m_code = kc - 10; m_mode = M_OPER; end
      M_OPER:   if (dig) begin m_b = kc; m_disp = kc; m_digits = 1; m_mode = M_SECOND; end
                else if (oper) m_code = kc - 10;
      M_SECOND: if (dig) m_b = append_digit(m_b, kc);
                else if (oper || eq) begin
                  m_start = 1; m_mode = M_BUSY; m_chain = oper; m_chain_code = kc - 10;
                end
      M_BUSY:   if (dn) begin
                  if (er) begin m_err = 1; m_disp = 0; m_mode = M_FAULT; end
                  else begin
                    m_a = rs; m_disp = rs;
                    if (m_chain) begin m_code = m_chain_code; m_chain = 0; m_mode = M_OPER; end
                    else m_mode = M_RESULT;
                  end
                end
      M_RESULT: if (dig) begin m_a = kc; m_disp = kc; m_digits = 1; m_mode = M_FIRST; end
                else if (oper) begin m_code = kc - 10; m_b = 0; m_mode = M_OPER; end
      default:  ;
    endcase
  endfunction

  task automatic compare_all();
    check_val("op_a", op_a, m_a);
    check_val("op_b", op_b, m_b);
    check_val("op_code", op_code, m_code);
    check_val("calc_start", calc_start, m_start);
    check_val("disp_val", disp_val, m_disp);
    check_val("error", error, m_err);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit kv, input int kc, input bit dn, input int rs, input bit er);
    key_valid = kv; key_value = kc[3:0];
    calc_done = dn; calc_result = rs[7:0]; calc_err = er;
    @(posedge clk);
    model_step(kv, kc, dn, rs, er);
    @(negedge clk);
    key_valid = 1'b0; calc_done = 1'b0; calc_err = 1'b0;
    compare_all();
  endtask

  task automatic press(input int kc);
    step(1'b1, kc, 1'b0, 0, 1'b0);
  endtask

  task automatic done(input int rs, input bit er);
    step(1'b0, 0, 1'b1, rs, er);
  endtask

  int done_cnt, pend_res, pend_err, r, kc, sel;
  bit kv, dn, er;
  int rs;

  initial begin
    reset = 1'b0; key_value = 4'd0; key_valid = 1'b0;
    calc_done = 1'b0; calc_result = 8'd0; calc_err = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // 123 + 45 = 168
    press(1); press(2); press(3); press(10); press(4); press(5); press(15);
    check_val("t1_start", calc_start, 1);
    check_val("t1_opa", op_a, 123);
    check_val("t1_opb", op_b, 45);
    check_val("t1_code", op_code, 0);
    press(7);  // ignored while busy
    check_val("t1_start_once", calc_start, 0);
    done(168, 1'b0);
    check_val("t1_disp", disp_val, 168);

    // overflow and digit limit
    press(14); press(2); press(5); press(6);
    check_val("t2_opa_ovf", op_a, 25);
    press(14); press(1); press(1); press(1); press(1);
    check_val("t2_opa_lim", op_a, 111);

    // divide by zero
    press(14); press(9); press(13); press(0); press(15);
    check_val("t3_start", calc_start, 1);
    done(0, 1'b1);
    check_val("t3_err", error, 1);
    check_val("t3_disp", disp_val, 0);
    press(5); press(10);
    check_val("t3_err_sticky", error, 1);
    press(14);
    check_val("t3_clr_err", error, 0);
    check_val("t3_clr_opa", op_a, 0);

    // chaining 5 * 3 - 4
    press(5); press(12); press(3); press(11);
    check_val("t4_start", calc_start, 1);
    check_val("t4_code_mul", op_code, 2);
    done(15, 1'b0);
    check_val("t4_opa", op_a, 15);
    check_val("t4_code_sub", op_code, 1);
    press(4); press(15);
    check_val("t4_start2", calc_start, 1);
    check_val("t4_opb", op_b, 4);
    done(11, 1'b0);
    check_val("t4_res", disp_val, 11);

    // clear together with calc_done, then a late done
    press(14); press(7); press(10); press(1); press(15);
    step(1'b1, 14, 1'b1, 8, 1'b0);
    check_val("t5_disp", disp_val, 0);
    done(99, 1'b0);
    check_val("t5_late", op_a, 0);

    // asynchronous reset mid-entry
    press(4); press(2);
    #2 reset = 1'b0;
    #1;
    m_reset();
    check_val("t6_opa", op_a, 0);
    check_val("t6_disp", disp_val, 0);
    check_val("t6_code", op_code, 0);
    @(negedge clk);
    reset = 1'b1;

    // random traffic with an emulated arithmetic unit
    done_cnt = 0; pend_res = 0; pend_err = 0;
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 50)      kc = $urandom_range(0, 9);
      else if (sel < 78) kc = $urandom_range(10, 13);
      else if (sel < 93) kc = 15;
      else               kc = 14;
      dn = 1'b0; rs = 0; er = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin dn = 1'b1; rs = pend_res; er = pend_err[0]; end
      end else if ($urandom_range(0, 49) == 0) begin
        dn = 1'b1; rs = $urandom_range(0, 255); er = $urandom_range(0, 1);
      end
      step(kv, kc, dn, rs, er);
      if (m_start != 0) begin
        done_cnt = $urandom_range(1, 4);
        case (m_code)
          0: r = m_a + m_b;
          1: r = m_a - m_b;
          2: r = m_a * m_b;
          default: r = (m_b == 0) ? -1 : m_a / m_b;
        endcase
        pend_err = (r < 0 || r > 255) ? 1 : 0;
        pend_res = pend_err ? 0 : r;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
